m_spi_master: RTL and testbench
===============================

M_SPI_MASTER -- requirements
Module: m_spi_master

Interface
REQ-001 SHALL have parameter WORD, default 8, meaning bits per transfer.
REQ-002 SHALL have parameter CLK_DIV, default 4, meaning CLK cycles per SCLK half-period; legal values are >= 2.
REQ-003 SHALL have port CLK, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port START, input, 1 bit: transfer request, sampled in IDLE.
REQ-006 SHALL have port TX_DATA, input, WORD bits: word to shift out, MSB first.
REQ-007 SHALL have port MISO, input, 1 bit: serial data from the slave.
REQ-008 SHALL have port SCLK, output, 1 bit: SPI clock, mode 0 (idle low, sample on rise, shift on fall).
REQ-009 SHALL have port MOSI, output, 1 bit: serial data to the slave.
REQ-010 SHALL have port SS, output, 1 bit: slave select, active low.
REQ-011 SHALL have port RX_DATA, output, WORD bits: last received word.
REQ-012 SHALL have port BUSY, output, 1 bit: high from START acceptance until DONE.
REQ-013 SHALL have port DONE, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 SHALL drive every output from a register, with no combinational path from any input to any output.
REQ-015 SHALL implement the states IDLE, LEAD, HIGH, LOW and TRAIL, using a half-period counter hc that runs 0..CLK_DIV-1 and a bit counter that runs 0..WORD-1.
REQ-016 IDLE: SHALL hold SS=1 and SCLK=0. On START=1, the next edge SHALL latch TX_DATA, set SS=0, BUSY=1, MOSI=TX_DATA[WORD-1], clear both counters, and go to LEAD.
REQ-017 LEAD/LOW: SHALL hold SCLK=0 for CLK_DIV cycles. On the final edge it SHALL set SCLK=1, shift MISO into the LSB of the rx shift register, and go to HIGH.
REQ-018 HIGH: SHALL hold SCLK=1 for CLK_DIV cycles. On the final edge it SHALL set SCLK=0, then: if bit count = WORD-1, go to TRAIL; otherwise increment the bit count, drive MOSI with the next lower TX bit, and go to LOW.
REQ-019 TRAIL: SHALL hold SCLK=0 and SS=0 for CLK_DIV cycles. On the final edge it SHALL set SS=1, BUSY=0, DONE=1, copy the rx shift register to RX_DATA, and go to IDLE.
REQ-020 The START-to-DONE latency SHALL be exactly 1 + CLK_DIV*(2*WORD+1) CLK cycles; for defaults this is 69.
REQ-021 DONE SHALL be high for exactly one cycle, namely the first IDLE cycle after a transfer.
REQ-022 START while BUSY=1 SHALL be ignored, and TX_DATA changes during a transfer SHALL have no effect.
REQ-023 START=1 in the DONE cycle SHALL be accepted, giving a back-to-back transfer with SS high for exactly one cycle.
REQ-024 RX_DATA SHALL change only on DONE and SHALL otherwise hold its value.
REQ-025 MOSI SHALL hold its value while SCLK=1; in IDLE it SHALL hold the last driven bit.
REQ-026 Exactly WORD rising SCLK edges SHALL occur per transfer, and SCLK SHALL never toggle while SS=1.

Reset
REQ-027 RST=1 SHALL immediately force, with no clock required: state=IDLE, SCLK=0, SS=1, MOSI=0, BUSY=0, DONE=0, RX_DATA=0, and all counters and shift registers=0.
REQ-028 RST asserted mid-transfer SHALL abort the transfer with no DONE pulse and leave RX_DATA=0; the first START after RST deasserts SHALL start a full new transfer.

Verification
REQ-029 The bench SHALL cover loopback: MISO tied to MOSI, TX_DATA=0xA5, START pulsed -> RX_DATA=0xA5, DONE 69 cycles after the START edge, exactly 8 SCLK rises.
REQ-030 The bench SHALL cover a slave model returning 0x3C with TX_DATA=0xC3 -> MOSI sampled at the SCLK rises reads 1,1,0,0,0,0,1,1; RX_DATA=0x3C.
REQ-031 The bench SHALL cover MISO held at 1 and TX_DATA=0x00 -> RX_DATA=0xFF; MOSI stays 0 throughout while SS=0.
REQ-032 The bench SHALL cover START re-pulsed with TX_DATA=0xFF at cycle 20 of a 0x12 transfer -> the transfer completes sending 0x12, with only one DONE pulse.
REQ-033 The bench SHALL cover RST asserted after the 3rd SCLK rise -> SS=1, SCLK=0, BUSY=0 and RX_DATA=0 in the same cycle; no DONE; a subsequent 0x5A loopback returns 0x5A.
REQ-034 The bench SHALL cover START held at 1 continuously with loopback 0x81 -> consecutive transfers 70 cycles apart, SS high for exactly 1 cycle between them, RX_DATA=0x81 each time.

Source files
------------

// File: rtl/m_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : m_spi_master                                               |
// | Description : Mode-0 SPI master. Shifts one WORD-bit word out on MOSI,    |
// |               MSB first, and captures WORD bits from MISO in the same     |
// |               transfer. SCLK half-period is CLK_DIV system clocks.        |
// | Ports       : CLK     - system clock, rising edge                         |
// |               RST     - asynchronous active-high reset                    |
// |               START   - transfer request, sampled only while idle         |
// |               TX_DATA - word to send                                      |
// |               MISO    - serial data from slave                            |
// |               SCLK    - SPI clock, idle low                               |
// |               MOSI    - serial data to slave                              |
// |               SS      - slave select, active low                          |
// |               RX_DATA - last received word                                |
// |               BUSY    - transfer in progress                              |
// |               DONE    - one-cycle completion pulse                        |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module m_spi_master #(
  parameter int WORD    = 8,
  parameter int CLK_DIV = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [WORD-1:0] TX_DATA,
  input  logic            MISO,
  output logic            SCLK,
  output logic            MOSI,
  output logic            SS,
  output logic [WORD-1:0] RX_DATA,
  output logic            BUSY,
  output logic            DONE
);

  localparam int HC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (WORD > 1) ? $clog2(WORD) : 1;

  localparam logic [HC_W-1:0]  c_hc_last  = HC_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(WORD - 1);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_lead  = 3'd1;
  localparam logic [2:0] c_st_high  = 3'd2;
  localparam logic [2:0] c_st_low   = 3'd3;
  localparam logic [2:0] c_st_trail = 3'd4;

  logic [2:0]       state_q,   state_d;
  logic [HC_W-1:0]  hc_q,      hc_d;
  logic [BIT_W-1:0] bit_q,     bit_d;
  logic             setup_q,   setup_d;
  logic [WORD-1:0]  tx_q,      tx_d;
  logic [WORD-1:0]  rx_sh_q,   rx_sh_d;
  logic [WORD-1:0]  rx_data_q, rx_data_d;
  logic             sclk_q,    sclk_d;
  logic             mosi_q,    mosi_d;
  logic             ss_q,      ss_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             hc_end;

  assign hc_end = (hc_q == c_hc_last);

  always_comb begin
    state_d   = state_q;
    hc_d      = hc_q;
    bit_d     = bit_q;
    setup_d   = setup_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_d      = ss_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      c_st_idle: begin
        if (START) begin
          // The MSB goes straight to MOSI; tx_q keeps only the bits still
          // to be sent, left-justified, so its MSB is always the next bit.
          tx_d    = {TX_DATA[WORD-2:0], 1'b0};
          mosi_d  = TX_DATA[WORD-1];
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          hc_d    = '0;
          bit_d   = '0;
          setup_d = 1'b1;
          state_d = c_st_lead;
        end
      end

      c_st_lead, c_st_low: begin
        // One extra SS-to-SCLK setup cycle precedes the first half-period,
        // giving the 1 + CLK_DIV*(2*WORD+1) START-to-DONE latency.
        if (setup_q) begin
          setup_d = 1'b0;
        end else if (hc_end) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[WORD-2:0], MISO};
          hc_d    = '0;
          state_d = c_st_high;
        end else begin
          hc_d = hc_q + HC_W'(1);
        end
      end

      c_st_high: begin
        if (hc_end) begin
          sclk_d = 1'b0;
          hc_d   = '0;
          if (bit_q == c_bit_last) begin
            state_d = c_st_trail;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            mosi_d  = tx_q[WORD-1];
            tx_d    = {tx_q[WORD-2:0], 1'b0};
            state_d = c_st_low;
          end
        end else begin
          hc_d = hc_q + HC_W'(1);
        end
      end

      c_st_trail: begin
        if (hc_end) begin
          ss_d      = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          hc_d      = '0;
          state_d   = c_st_idle;
        end else begin
          hc_d = hc_q + HC_W'(1);
        end
      end

      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= c_st_idle;
      hc_q      <= '0;
      bit_q     <= '0;
      setup_q   <= 1'b0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hc_q      <= hc_d;
      bit_q     <= bit_d;
      setup_q   <= setup_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign SS      = ss_q;
  assign RX_DATA = rx_data_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_m_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_m_spi_master                                            |
// | Description : Self-checking bench for m_spi_master with a transfer-level  |
// |               reference model and directed scenarios.                     |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_m_spi_master;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int LAT = 1 + D * (2 * W + 1);

  logic       CLK     = 1'b0;
  logic       RST     = 1'b1;
  logic       START   = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       MISO;
  logic       SCLK;
  logic       MOSI;
  logic       SS;
  logic [7:0] RX_DATA;
  logic       BUSY;
  logic       DONE;

  always #5 CLK = ~CLK;

  m_spi_master #(.WORD(W), .CLK_DIV(D)) u_dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .TX_DATA (TX_DATA),
    .MISO    (MISO),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .SS      (SS),
    .RX_DATA (RX_DATA),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  int n_err    = 0;
  int n_checks = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Free-running observation counters; scenarios take differences.
  int         cyc         = 0;
  int         rises       = 0;
  int         falls       = 0;
  int         done_cnt    = 0;
  int         ss_hi_cnt   = 0;
  int         mosi_hi_cnt = 0;
  logic [7:0] mosi_hist   = 8'h00;

  always @(posedge CLK)  cyc <= cyc + 1;
  always @(posedge SCLK) rises <= rises + 1;
  always @(posedge SCLK) mosi_hist <= {mosi_hist[6:0], MOSI};
  always @(negedge SCLK) falls <= falls + 1;
  always @(negedge CLK) begin
    if (DONE)         done_cnt    <= done_cnt + 1;
    if (SS)           ss_hi_cnt   <= ss_hi_cnt + 1;
    if (!SS && MOSI)  mosi_hi_cnt <= mosi_hi_cnt + 1;
  end

  // MISO source: 0 = loopback, 1 = slave shifting slave_word on SCLK falls,
  // anything else = constant 1.
  int         miso_mode  = 0;
  logic [7:0] slave_word = 8'h00;
  int         fall_base  = 0;
  int         slv_idx;

  always_comb begin
    slv_idx = falls - fall_base;
    MISO    = 1'b0;
    case (miso_mode)
      0: MISO = MOSI;
      1: if (slv_idx >= 0 && slv_idx < 8) MISO = slave_word[7 - slv_idx];
      default: MISO = 1'b1;
    endcase
  end

  // ---------------- reference model ----------------
  // Timeline in CLK edges counted from the accepting edge (n = 0):
  // one setup cycle, then rise k at 1+D+2Dk, fall k at 1+2D+2Dk,
  // completion at n = LAT.
  function automatic bit is_rise(input int n);
    return (n >= 1 + D) && ((n - 1 - D) % (2 * D) == 0) && ((n - 1 - D) / (2 * D) < W);
  endfunction

  function automatic bit is_shift(input int n);
    return (n >= 1 + 2 * D) && ((n - 1 - 2 * D) % (2 * D) == 0) && ((n - 1 - 2 * D) / (2 * D) < W - 1);
  endfunction

  function automatic bit sclk_at(input int n);
    return (n >= 1 + D) && ((n - 1 - D) / (2 * D) < W) && ((n - 1 - D) % (2 * D) < D);
  endfunction

  logic       m_active;
  int         m_n;
  logic [7:0] m_tx;
  logic [7:0] m_rx_sh;
  logic [7:0] m_rx;
  logic       m_done;
  logic       m_mosi;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_active <= 1'b0;
      m_n      <= 0;
      m_tx     <= 8'h00;
      m_rx_sh  <= 8'h00;
      m_rx     <= 8'h00;
      m_done   <= 1'b0;
      m_mosi   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        m_n <= m_n + 1;
        if (m_n == LAT - 1) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
          m_rx     <= m_rx_sh;
        end
        if (is_rise(m_n + 1))  m_rx_sh <= {m_rx_sh[6:0], MISO};
        if (is_shift(m_n + 1)) m_mosi  <= m_tx[W - 2 - (m_n - 2 * D) / (2 * D)];
      end else if (START) begin
        m_active <= 1'b1;
        m_n      <= 0;
        m_tx     <= TX_DATA;
        m_mosi   <= TX_DATA[7];
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        chk("ss",   SS,      !m_active);
        chk("busy", BUSY,    m_active);
        chk("sclk", SCLK,    m_active && sclk_at(m_n));
        chk("mosi", MOSI,    m_mosi);
        chk("done", DONE,    m_done);
        chk("rx",   RX_DATA, m_rx);
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Steps at least once, then waits for DONE; lat = cycles since t0 or -1.
  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (DONE) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output int lat);
    int t0;
    TX_DATA = tx;
    START   = 1'b1;
    step();
    t0    = cyc;
    START = 1'b0;
    wait_done(t0, lat);
  endtask

  initial begin
    int lat, t0, r0, d0, m0, s1, d1, d2;
    RST = 1'b1;
    repeat (3) step();
    chk("rst_ss",   SS,      1);
    chk("rst_sclk", SCLK,    0);
    chk("rst_mosi", MOSI,    0);
    chk("rst_busy", BUSY,    0);
    chk("rst_done", DONE,    0);
    chk("rst_rx",   RX_DATA, 0);
    chk_en = 1'b1;
    RST    = 1'b0;
    repeat (2) step();

    // Loopback 0xA5.
    miso_mode = 0;
    r0 = rises;
    xfer(8'hA5, lat);
    chk("A5_latency", lat, 69);
    chk("A5_rises",   rises - r0, 8);
    chk("A5_rx",      RX_DATA, 8'hA5);
    repeat (3) step();

    // Slave returns 0x3C while master sends 0xC3.
    miso_mode  = 1;
    slave_word = 8'h3C;
    fall_base  = falls;
    xfer(8'hC3, lat);
    chk("C3_latency", lat, 69);
    chk("C3_mosi_at_rises", mosi_hist, 8'b1100_0011);
    chk("C3_rx",      RX_DATA, 8'h3C);
    repeat (3) step();

    // MISO stuck high, sending zeros.
    miso_mode = 2;
    m0 = mosi_hi_cnt;
    xfer(8'h00, lat);
    chk("FF_latency", lat, 69);
    chk("FF_rx",      RX_DATA, 8'hFF);
    chk("FF_mosi_low", mosi_hi_cnt - m0, 0);
    repeat (3) step();

    // START re-pulsed with new data during a 0x12 transfer.
    miso_mode = 0;
    d0 = done_cnt;
    TX_DATA = 8'h12;
    START   = 1'b1;
    step();
    t0    = cyc;
    START = 1'b0;
    while (cyc - t0 < 20) step();
    TX_DATA = 8'hFF;
    START   = 1'b1;
    step();
    START = 1'b0;
    wait_done(t0, lat);
    chk("repulse_latency", lat, 69);
    chk("repulse_rx",      RX_DATA, 8'h12);
    repeat (3) step();
    chk("repulse_one_done", done_cnt - d0, 1);

    // Reset after the third SCLK rise.
    r0 = rises;
    TX_DATA = 8'h96;
    START   = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 100 && (rises - r0) < 3; i++) step();
    chk("abort_reached_rise3", rises - r0, 3);
    d0  = done_cnt;
    RST = 1'b1;
    #1;
    chk("abort_ss",   SS,      1);
    chk("abort_sclk", SCLK,    0);
    chk("abort_busy", BUSY,    0);
    chk("abort_rx",   RX_DATA, 0);
    step();
    RST = 1'b0;
    repeat (80) step();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_rx_held", RX_DATA, 0);
    xfer(8'h5A, lat);
    chk("5A_latency", lat, 69);
    chk("5A_rx",      RX_DATA, 8'h5A);
    repeat (3) step();

    // START held high: back-to-back loopback 0x81.
    TX_DATA = 8'h81;
    START   = 1'b1;
    step();
    t0 = cyc;
    wait_done(t0, lat);
    chk("b2b_first_latency", lat, 69);
    chk("b2b_rx1", RX_DATA, 8'h81);
    d1 = cyc;
    s1 = ss_hi_cnt;
    wait_done(d1, lat);
    chk("b2b_period1", lat, 70);
    chk("b2b_ss_gap",  ss_hi_cnt - s1, 1);
    chk("b2b_rx2",     RX_DATA, 8'h81);
    d2 = cyc;
    wait_done(d2, lat);
    START = 1'b0;
    chk("b2b_period2", lat, 70);
    chk("b2b_rx3",     RX_DATA, 8'h81);
    repeat (5) step();
    chk("b2b_idle_busy", BUSY, 0);
    chk("b2b_idle_ss",   SS,   1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
